z_result_stage: RTL and testbench
=================================

# z_result_stage

Result-capture stage sitting directly downstream of the combinational ALU: it registers each ALU result (low word, plus high word for multiply/divide), buffers it in a small FIFO, and drains it onto the 32-bit result bus as one or two beats under a valid/ready handshake. It decouples the single-cycle ALU from the slower writeback path. It also flags illegal opcodes and divide-by-zero.

## Interface
- DEPTH, 2, FIFO entries; power of two, 2..8
- clock  in  1  sole clock, rising edge
- clear_n  in  1  synchronous, active-low reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept; high when FIFO count < DEPTH
- in_op  in  4  ALU opcode that produced the result
- in_lo  in  32  ALU low result (alu_out)
- in_hi  in  32  ALU high result (alu_out2), used only for wide ops
- in_b  in  32  ALU B operand, used for divide-by-zero detection
- bus_valid  out  1  beat valid on bus_data
- bus_ready  in  1  consumer accepts beat
- bus_data  out  32  beat payload
- bus_hi  out  1  current beat is the high word
- bus_last  out  1  final beat of current result
- bus_err  out  1  result carries divide-by-zero
- flag_z  out  1  result zero (see Configuration)
- flag_n  out  1  result negative (see Configuration)
- drop_cnt  out  8  count of dropped illegal-op results, saturating at 255

## Operation
- Push: in_valid && in_ready stores {op, lo, hi, err}; err = (op==DIV && in_b==0).
- Legal ops: 0001..1011. Wide ops: 0011 (DIV), 0100 (MUL). Others narrow.
- Illegal op (0000, 1100..1111) with in_valid && in_ready: not stored, drop_cnt += 1 (saturating); in_ready unaffected.
- Drain FSM, states IDLE, LO, HI:
  - IDLE: FIFO empty, bus_valid=0. Non-empty -> LO.
  - LO: bus_data=head.lo, bus_hi=0, bus_last=!wide(head.op). On bus_ready: wide -> HI; narrow -> pop, LO if FIFO still non-empty after pop, else IDLE.
  - HI: bus_data=head.hi, bus_hi=1, bus_last=1. On bus_ready: pop, LO or IDLE as above.
- bus_err = head.err, held for both beats of a divide.
- bus_valid high in LO and HI; outputs stable while bus_valid && !bus_ready.
- Simultaneous push and pop: both occur; count unchanged. Push when count==DEPTH impossible (in_ready low), even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- clear_n low: count=0, pointers=0, state IDLE, drop_cnt=0; in-flight beats discarded, including mid-HI.

## Timing
- Reset values: in_ready=1 from the first cycle after reset, bus_valid=0, bus_data=0, bus_hi=0, bus_last=0, bus_err=0, flag_z=0, flag_n=0, drop_cnt=0.
- Latency: result pushed in cycle N is first visible on the bus in cycle N+1 (registered FIFO head, no bypass).
- Throughput: one narrow result per cycle with bus_ready held high. Wide results take 2 cycles each.
- in_ready is a registered function of count only, with no combinational path from bus_ready.

## Configuration
- Z_RESULT_FLAGS_EN defined: flag_z and flag_n are computed at push and stored per entry.
  - Narrow ops: Z = (lo==0), N = lo[31].
  - Wide ops: Z = ({hi,lo}==0), N = hi[31].
  - Both flags are presented alongside bus_valid for both beats.
- Undefined: no flag storage; flag_z and flag_n tied to 0. Ports retained.

## Structure
- Shared package alu_pkg: opcode constants (OP_ADD 4'b0001 … OP_ROL 4'b1011), functions is_wide(op) and is_legal(op), and the FIFO entry struct typedef.
- Sub-module result_fifo (parameter DEPTH, entry-width generic): storage, pointers, count, full/empty. The drain FSM, error detection and drop counter live in z_result_stage.

## Test plan
- ADD result lo=0x0000_0005, bus_ready=1 -> next cycle bus_data=5, bus_last=1, bus_hi=0; one beat only.
- MUL lo=0xFFFF_FFFE, hi=0xFFFF_FFFF -> beats 0xFFFF_FFFE (bus_hi=0, last=0) then 0xFFFF_FFFF (bus_hi=1, last=1); with flags enabled, flag_n=1 and flag_z=0.
- DIV with in_b=0 -> two beats, bus_err=1 on both; next ADD has bus_err=0.
- bus_ready=0, push 2 results -> in_ready=0; third in_valid is held. Release bus_ready -> results emerge in order and in_ready returns to 1.
- in_op=4'b1111 three times -> nothing on the bus, drop_cnt=3; 300 illegal pushes -> drop_cnt=255.
- clear_n low during the HI beat -> next cycle bus_valid=0, in_ready=1, FIFO empty, drop_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, opcode classification helpers,
// drain FSM state type and the result FIFO entry layout.
// Optional feature macro: Z_RESULT_FLAGS_EN adds per-entry zero/negative flags.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              err;
`ifdef Z_RESULT_FLAGS_EN
    logic              z;
    logic              n;
`endif
  } fifo_entry_t;

  // Wide ops produce a high word and drain as two beats.
  function automatic logic is_wide(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: registered storage, wrapping pointers and occupancy count.
// Ports:
//   clock, clear_n       - clock, synchronous active-low reset
//   i_push, i_wdata      - write request and entry
//   i_pop                - remove head entry
//   o_head_nxt_c         - head entry as it will be after this cycle's push/pop
//   o_empty_nxt_c        - FIFO will be empty after this cycle
//   o_full_nxt_c         - FIFO will be full after this cycle
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head_nxt_c,
  output logic             o_empty_nxt_c,
  output logic             o_full_nxt_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_after_pop;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow so pointers never desynchronise.
  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != CW'(0));

  assign w_rd_ptr_nxt      = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_count_nxt       = w_count_after_pop + CW'(w_push);

  assign o_empty_nxt_c = (w_count_nxt == CW'(0));
  assign o_full_nxt_c  = (w_count_nxt == CW'(DEPTH));

  // An entry written into an (effectively) empty FIFO becomes the next head.
  assign o_head_nxt_c = (w_push && (w_count_after_pop == CW'(0))) ? i_wdata
                                                                  : r_mem[w_rd_ptr_nxt];

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/z_result_stage.sv
// Result-capture stage behind the ALU: buffers results in a FIFO and drains
// each one as one (narrow) or two (wide: lo then hi) beats on a valid/ready bus.
// Flags divide-by-zero per result and counts dropped illegal-op results.
// Optional feature macro: Z_RESULT_FLAGS_EN (zero/negative flags per result).
// Ports:
//   clock, clear_n                - clock, synchronous active-low reset
//   in_valid/in_ready             - ALU result handshake
//   in_op, in_lo, in_hi, in_b     - opcode, low/high result, B operand
//   bus_valid/bus_ready           - result bus handshake
//   bus_data, bus_hi, bus_last    - beat payload, high-word beat, final beat
//   bus_err                       - result is a divide by zero
//   flag_z, flag_n                - result zero / negative (0 when feature off)
//   drop_cnt                      - saturating count of dropped illegal ops
module z_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_lo,
  input  logic [31:0] in_hi,
  input  logic [31:0] in_b,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_data,
  output logic        bus_hi,
  output logic        bus_last,
  output logic        bus_err,
  output logic        flag_z,
  output logic        flag_n,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  drain_state_e r_state;
  drain_state_e w_state_nxt;

  logic        r_in_ready;
  logic        r_bus_valid;
  logic [31:0] r_bus_data;
  logic        r_bus_hi;
  logic        r_bus_last;
  logic        r_bus_err;
  logic [7:0]  r_drop_cnt;

  logic        w_bus_valid_nxt;
  logic [31:0] w_bus_data_nxt;
  logic        w_bus_hi_nxt;
  logic        w_bus_last_nxt;
  logic        w_bus_err_nxt;

  logic        w_accept;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_empty_nxt;
  logic        w_full_nxt;
  fifo_entry_t w_wentry;
  fifo_entry_t w_head_nxt;

  assign w_accept = in_valid && r_in_ready;
  assign w_push   = w_accept && is_legal(in_op);
  assign w_drop   = w_accept && !is_legal(in_op);

  // The registered beat's bus_last marks the beat that retires the head entry.
  assign w_pop = r_bus_valid && bus_ready && r_bus_last;

  // Entry captured at push time.
  always_comb begin
    w_wentry     = '0;
    w_wentry.op  = in_op;
    w_wentry.lo  = in_lo;
    w_wentry.hi  = in_hi;
    w_wentry.err = (in_op == OP_DIV) && (in_b == 32'd0);
`ifdef Z_RESULT_FLAGS_EN
    if (is_wide(in_op)) begin
      w_wentry.z = ({in_hi, in_lo} == 64'd0);
      w_wentry.n = in_hi[31];
    end else begin
      w_wentry.z = (in_lo == 32'd0);
      w_wentry.n = in_lo[31];
    end
`endif
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock         (clock),
    .clear_n       (clear_n),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_wdata       (w_wentry),
    .o_head_nxt_c  (w_head_nxt),
    .o_empty_nxt_c (w_empty_nxt),
    .o_full_nxt_c  (w_full_nxt)
  );

  // Drain FSM next state and next registered beat.
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_valid_nxt = 1'b0;
    w_bus_data_nxt  = 32'd0;
    w_bus_hi_nxt    = 1'b0;
    w_bus_last_nxt  = 1'b0;
    w_bus_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty_nxt) w_state_nxt = ST_LO;
      end
      ST_LO: begin
        if (bus_ready) begin
          if (!r_bus_last)      w_state_nxt = ST_HI;
          else if (w_empty_nxt) w_state_nxt = ST_IDLE;
          else                  w_state_nxt = ST_LO;
        end
      end
      ST_HI: begin
        if (bus_ready) w_state_nxt = w_empty_nxt ? ST_IDLE : ST_LO;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_bus_valid_nxt = (w_state_nxt != ST_IDLE);
    if (w_bus_valid_nxt) begin
      w_bus_hi_nxt   = (w_state_nxt == ST_HI);
      w_bus_data_nxt = w_bus_hi_nxt ? w_head_nxt.hi : w_head_nxt.lo;
      w_bus_last_nxt = w_bus_hi_nxt || !is_wide(w_head_nxt.op);
      w_bus_err_nxt  = w_head_nxt.err;
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_bus_valid <= 1'b0;
      r_bus_data  <= 32'd0;
      r_bus_hi    <= 1'b0;
      r_bus_last  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= !w_full_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_bus_data  <= w_bus_data_nxt;
      r_bus_hi    <= w_bus_hi_nxt;
      r_bus_last  <= w_bus_last_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  // Saturating illegal-op drop counter.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

`ifdef Z_RESULT_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  // Flags follow the head entry for every beat of the result.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else begin
      r_flag_z <= w_bus_valid_nxt && w_head_nxt.z;
      r_flag_n <= w_bus_valid_nxt && w_head_nxt.n;
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign bus_valid = r_bus_valid;
  assign bus_data  = r_bus_data;
  assign bus_hi    = r_bus_hi;
  assign bus_last  = r_bus_last;
  assign bus_err   = r_bus_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_z_result_stage.sv
// Testbench for z_result_stage: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_z_result_stage;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_lo;
  logic [31:0] in_hi;
  logic [31:0] in_b;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_data;
  logic        bus_hi;
  logic        bus_last;
  logic        bus_err;
  logic        flag_z;
  logic        flag_n;
  logic [7:0]  drop_cnt;

  always #5 clock = ~clock;

  z_result_stage #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .in_b      (in_b),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_hi    (bus_hi),
    .bus_last  (bus_last),
    .bus_err   (bus_err),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } res_t;

  res_t mq[$];
  res_t nr;
  res_t cur;
  int   beat;
  int   drops;
  int   checks;
  int   errors;
  bit   started;
  bit   m_rdy;

  function automatic bit m_wide(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted results, beat index into the head.
  always @(posedge clock) begin
    if (!clear_n) begin
      mq.delete();
      beat  = 0;
      drops = 0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      if (mq.size() > 0 && bus_ready) begin
        if (m_wide(mq[0].op) && beat == 0) beat = 1;
        else begin
          void'(mq.pop_front());
          beat = 0;
        end
      end
      if (in_valid && m_rdy) begin
        if (in_op >= 4'd1 && in_op <= 4'd11) begin
          nr.op  = in_op;
          nr.lo  = in_lo;
          nr.hi  = in_hi;
          nr.err = (in_op == 4'd3) && (in_b == 32'd0);
          mq.push_back(nr);
        end else if (drops < 255) begin
          drops++;
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clock) begin
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("bus_valid", 64'(bus_valid), 64'(mq.size() > 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(drops));
      if (mq.size() > 0) begin
        cur = mq[0];
        chk("bus_data", 64'(bus_data), 64'((beat == 1) ? cur.hi : cur.lo));
        chk("bus_hi", 64'(bus_hi), 64'(beat == 1));
        chk("bus_last", 64'(bus_last), 64'((beat == 1) || !m_wide(cur.op)));
        chk("bus_err", 64'(bus_err), 64'(cur.err));
`ifdef Z_RESULT_FLAGS_EN
        if (m_wide(cur.op)) begin
          chk("flag_z", 64'(flag_z), 64'({cur.hi, cur.lo} == 64'd0));
          chk("flag_n", 64'(flag_n), 64'(cur.hi[31]));
        end else begin
          chk("flag_z", 64'(flag_z), 64'(cur.lo == 32'd0));
          chk("flag_n", 64'(flag_n), 64'(cur.lo[31]));
        end
`endif
      end
`ifndef Z_RESULT_FLAGS_EN
      chk("flag_z_off", 64'(flag_z), 64'd0);
      chk("flag_n_off", 64'(flag_n), 64'd0);
`endif
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] lo,
                       input logic [31:0] hi, input logic [31:0] b, input logic rdy);
    in_valid  = v;
    in_op     = op;
    in_lo     = lo;
    in_hi     = hi;
    in_b      = b;
    bus_ready = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] b;
    logic        v;
    logic        rdy;
    int          sel;

    checks  = 0;
    errors  = 0;
    started = 0;
    clear_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    repeat (3) step();
    clear_n = 1'b1;
    started = 1;

    // Reset state
    @(negedge clock);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_bus_data", 64'(bus_data), 64'd0);
    chk("rst_bus_last", 64'(bus_last), 64'd0);

    // Narrow ADD: single beat one cycle after push
    step();
    drive(1'b1, 4'd1, 32'd5, 32'd0, 32'd1, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("add_valid", 64'(bus_valid), 64'd1);
    chk("add_data", 64'(bus_data), 64'd5);
    chk("add_last", 64'(bus_last), 64'd1);
    chk("add_hi", 64'(bus_hi), 64'd0);
    step();
    @(negedge clock);
    chk("add_one_beat", 64'(bus_valid), 64'd0);

    // Wide MUL: lo beat then hi beat
    drive(1'b1, 4'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("mul_lo_data", 64'(bus_data), 64'hFFFF_FFFE);
    chk("mul_lo_hi", 64'(bus_hi), 64'd0);
    chk("mul_lo_last", 64'(bus_last), 64'd0);
`ifdef Z_RESULT_FLAGS_EN
    chk("mul_flag_n", 64'(flag_n), 64'd1);
    chk("mul_flag_z", 64'(flag_z), 64'd0);
`endif
    step();
    @(negedge clock);
    chk("mul_hi_data", 64'(bus_data), 64'hFFFF_FFFF);
    chk("mul_hi_hi", 64'(bus_hi), 64'd1);
    chk("mul_hi_last", 64'(bus_last), 64'd1);
    step();
    @(negedge clock);
    chk("mul_done", 64'(bus_valid), 64'd0);

    // DIV by zero followed by ADD
    drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd7, 32'd0, 1'b1);
    step();
    drive(1'b1, 4'd1, 32'd9, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("div_lo_err", 64'(bus_err), 64'd1);
    chk("div_lo_data", 64'(bus_data), 64'hFFFF_FFFF);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("div_hi_err", 64'(bus_err), 64'd1);
    chk("div_hi_data", 64'(bus_data), 64'd7);
    step();
    @(negedge clock);
    chk("add_after_div_err", 64'(bus_err), 64'd0);
    chk("add_after_div_data", 64'(bus_data), 64'd9);
    step();

    // Backpressure: fill FIFO, hold a third result, then release
    drive(1'b1, 4'd1, 32'h11, 32'd0, 32'd1, 1'b0);
    step();
    drive(1'b1, 4'd2, 32'h22, 32'd0, 32'd1, 1'b0);
    step();
    drive(1'b1, 4'd7, 32'h33, 32'd0, 32'd1, 1'b0);
    @(negedge clock);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_data", 64'(bus_data), 64'h11);
    step();
    @(negedge clock);
    chk("bp_stable", 64'(bus_data), 64'h11);
    drive(1'b1, 4'd7, 32'h33, 32'd0, 32'd1, 1'b1);
    step();
    @(negedge clock);
    chk("bp_second", 64'(bus_data), 64'h22);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("bp_third", 64'(bus_data), 64'h33);
    step();
    @(negedge clock);
    chk("bp_drained", 64'(bus_valid), 64'd0);

    // Illegal opcodes are dropped and counted
    repeat (3) begin
      drive(1'b1, 4'hF, 32'h1, 32'd0, 32'd1, 1'b1);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("drop_three", 64'(drop_cnt), 64'd3);
    chk("drop_no_bus", 64'(bus_valid), 64'd0);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 4);
      op  = (sel == 0) ? 4'd0 : 4'(11 + sel);
      drive(1'b1, op, $urandom, $urandom, $urandom, 1'b1);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    chk("drop_sat", 64'(drop_cnt), 64'd255);

    // Clear during the HI beat of a MUL
    drive(1'b1, 4'd4, 32'h1234, 32'h8000_0000, 32'd1, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    clear_n = 1'b0;
    @(negedge clock);
    chk("clr_in_hi", 64'(bus_hi), 64'd1);
    step();
    clear_n = 1'b1;
    @(negedge clock);
    chk("clr_valid", 64'(bus_valid), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    @(negedge clock);
    chk("clr_empty", 64'(bus_valid), 64'd0);

    // Randomized traffic; the last stretch holds bus_ready high
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 99);
      if (sel < 85) op = 4'($urandom_range(1, 11));
      else begin
        sel = $urandom_range(0, 4);
        op  = (sel == 0) ? 4'd0 : 4'(11 + sel);
      end
      lo  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      hi  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rdy = (i >= 2400) ? 1'b1 : ($urandom_range(0, 99) < 65);
      drive(v, op, lo, hi, b, rdy);
      clear_n = (i >= 2400) ? 1'b1 : ($urandom_range(0, 499) != 0);
      step();
    end
    clear_n = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
